// File: rtl/aes_decrypt_engine.sv
// aes_decrypt_engine -- iterative AES-128 inverse cipher, one inverse round
// per clock, with on-the-fly key expansion into a round-key store.
//
// Ports:
//   clk       in   clock, all logic on posedge
//   rst       in   asynchronous active-low reset
//   anahtar   in   [127:0] cipher key, byte 0 in [127:120]
//   sifre     in   [127:0] ciphertext, byte 0 in [127:120]
//   g_gecerli in   input valid; accepted when g_gecerli && hazir at posedge
//   hazir     out  engine idle, able to accept
//   blok      out  [127:0] recovered plaintext, registered
//   c_gecerli out  one-cycle pulse marking blok valid
//
// Optional feature macro: AES_DEC_KEYCACHE_EN. When defined, the expanded
// round keys are reused for a block whose key matches the previous one,
// skipping expansion (10-cycle latency instead of 21).
module aes_decrypt_engine #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] anahtar,
  input  logic [127:0] sifre,
  input  logic         g_gecerli,
  output logic         hazir,
  output logic [127:0] blok,
  output logic         c_gecerli
);
  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_INIT, S_ROUND} st_t;

  localparam logic [3:0] KLAST = 4'(NR);
  localparam logic [3:0] RLAST = 4'(NR - 1);

  // GF(2^8) helpers, polynomial 0x11b
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00; aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // x^254 = x^(2+4+...+128); maps 0 to 0 naturally
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r, p;
    r = 8'h01; p = x;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] x);
    return ginv(rl(x, 1) ^ rl(x, 3) ^ rl(x, 6) ^ 8'h05);
  endfunction

  // state byte r+4c lives at [127-8*(r+4c) -: 8]; row r rotates right by r
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = isbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a [4];
    logic [7:0] m9 [4], mb [4], md [4], me [4];
    logic [7:0] x2, x4, x8;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        a[r] = s[127-8*(r+4*c) -: 8];
        x2 = xt(a[r]); x4 = xt(x2); x8 = xt(x4);
        m9[r] = x8 ^ a[r];
        mb[r] = x8 ^ x2 ^ a[r];
        md[r] = x8 ^ x4 ^ a[r];
        me[r] = x8 ^ x4 ^ x2;
      end
      o[127-8*(4*c)   -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      o[127-8*(4*c+1) -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      o[127-8*(4*c+2) -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      o[127-8*(4*c+3) -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] k);
    case (k)
      4'd1: return 8'h01;  4'd2: return 8'h02;  4'd3: return 8'h04;
      4'd4: return 8'h08;  4'd5: return 8'h10;  4'd6: return 8'h20;
      4'd7: return 8'h40;  4'd8: return 8'h80;  4'd9: return 8'h1b;
      4'd10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] p, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(p[23:16]), sbox(p[15:8]), sbox(p[7:0]), sbox(p[31:24])} ^ {rc, 24'h0};
    n0 = p[127:96] ^ t;
    n1 = p[95:64]  ^ n0;
    n2 = p[63:32]  ^ n1;
    n3 = p[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  st_t                 r_st;
  logic [NR:0][127:0]  r_rk;
  logic [127:0]        r_state, r_sifre, r_blok;
  logic [3:0]          r_kcnt, r_rcnt;
  logic                r_cg;
  logic                w_hit;
  logic [127:0]        w_rk_next, w_ark, w_imc;

`ifdef AES_DEC_KEYCACHE_EN
  logic r_key_valid;
  // rk[0] is the captured key itself, so it doubles as the cache tag
  assign w_hit = r_key_valid && (anahtar == r_rk[0]);
`else
  assign w_hit = 1'b0;
`endif

  assign w_rk_next = key_step(r_rk[r_kcnt - 4'd1], rcon(r_kcnt));
  assign w_ark     = inv_sub_bytes(inv_shift_rows(r_state)) ^ r_rk[r_rcnt];
  assign w_imc     = inv_mix(w_ark);

  assign hazir     = (r_st == S_IDLE);
  assign blok      = r_blok;
  assign c_gecerli = r_cg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_st    <= S_IDLE;
      r_rk    <= '0;
      r_state <= '0;
      r_sifre <= '0;
      r_blok  <= '0;
      r_kcnt  <= '0;
      r_rcnt  <= '0;
      r_cg    <= 1'b0;
`ifdef AES_DEC_KEYCACHE_EN
      r_key_valid <= 1'b0;
`endif
    end else begin
      r_cg <= 1'b0;
      case (r_st)
        S_IDLE: if (g_gecerli) begin
          r_sifre <= sifre;
          if (w_hit) begin
            r_state <= sifre ^ r_rk[NR];
            r_rcnt  <= RLAST;
            r_st    <= S_ROUND;
          end else begin
            r_rk[0] <= anahtar;
            r_kcnt  <= 4'd1;
            r_st    <= S_EXPAND;
`ifdef AES_DEC_KEYCACHE_EN
            r_key_valid <= 1'b0;
`endif
          end
        end
        S_EXPAND: begin
          r_rk[r_kcnt] <= w_rk_next;
          if (r_kcnt == KLAST) begin
            r_st <= S_INIT;
`ifdef AES_DEC_KEYCACHE_EN
            r_key_valid <= 1'b1;
`endif
          end else begin
            r_kcnt <= r_kcnt + 4'd1;
          end
        end
        S_INIT: begin
          r_state <= r_sifre ^ r_rk[NR];
          r_rcnt  <= RLAST;
          r_st    <= S_ROUND;
        end
        S_ROUND: begin
          if (r_rcnt == 4'd0) begin
            r_blok <= w_ark;
            r_cg   <= 1'b1;
            r_st   <= S_IDLE;
          end else begin
            r_state <= w_imc;
            r_rcnt  <= r_rcnt - 4'd1;
          end
        end
        default: r_st <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_decrypt_engine.sv
// Bench for aes_decrypt_engine. Reference model is a table-driven forward
// AES-128 encryptor (S-box built by the 3-generator walk); random plaintexts
// are encrypted by the model and must come back from the DUT unchanged.
module tb_aes_decrypt_engine;
`ifdef AES_DEC_KEYCACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic         clk, rst, g_gecerli, hazir, c_gecerli;
  logic [127:0] anahtar, sifre, blok;

  aes_decrypt_engine #(.NR(10)) dut (
    .clk(clk), .rst(rst), .anahtar(anahtar), .sifre(sifre),
    .g_gecerli(g_gecerli), .hazir(hazir), .blok(blok), .c_gecerli(c_gecerli)
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  int checks = 0, failures = 0;
  int npulse = 0, exp_pulses = 0;
  bit         cvalid = 1'b0;
  logic [127:0] ckey = '0;

  logic [7:0]   sbox_t [256];
  logic [127:0] rk_m [11];

  always @(negedge clk) if (c_gecerli) npulse++;

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rot8(input logic [7:0] b, input int n);
    logic [7:0] t;
    t = (b << n) | (b >> (8 - n));
    return t;
  endfunction

  function automatic logic [7:0] m2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01; q = 8'h01;
    do begin
      p = p ^ m2(p);                                   // p *= 3
      q = q ^ (q << 1); q = q ^ (q << 2); q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;                         // q /= 3
      x = q ^ rot8(q, 1) ^ rot8(q, 2) ^ rot8(q, 3) ^ rot8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = m2(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic encrypt(input logic [127:0] k, input logic [127:0] pt, output logic [127:0] ct);
    logic [127:0] s, t;
    logic [7:0] a0, a1, a2, a3;
    expand(k);
    s = pt ^ rk_m[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[127-8*i -: 8] = sbox_t[s[127-8*i -: 8]];
      t = s;
      for (int rr = 0; rr < 4; rr++)
        for (int c = 0; c < 4; c++)
          s[127-8*(rr+4*c) -: 8] = t[127-8*(rr+4*((c+rr)%4)) -: 8];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[127-8*(4*c) -: 8];   a1 = s[127-8*(4*c+1) -: 8];
          a2 = s[127-8*(4*c+2) -: 8]; a3 = s[127-8*(4*c+3) -: 8];
          s[127-8*(4*c)   -: 8] = m2(a0) ^ m2(a1) ^ a1 ^ a2 ^ a3;
          s[127-8*(4*c+1) -: 8] = a0 ^ m2(a1) ^ m2(a2) ^ a2 ^ a3;
          s[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ m2(a2) ^ m2(a3) ^ a3;
          s[127-8*(4*c+3) -: 8] = m2(a0) ^ a0 ^ a1 ^ a2 ^ m2(a3);
        end
      end
      s = s ^ rk_m[r];
    end
    ct = s;
  endtask

  // Called with time just past a posedge. Returns just past the posedge that
  // raised c_gecerli, so a back-to-back call submits in the c_gecerli cycle.
  task automatic run_blk(input string tag, input logic [127:0] k, input logic [127:0] ct,
                         input logic [127:0] pt, input bit hold);
    int n, lat;
    lat = (CACHE && cvalid && ckey == k) ? 10 : 21;
    n = 0;
    while (!hazir && n < 50) begin @(posedge clk); #1; n++; end
    anahtar = k; sifre = ct; g_gecerli = 1'b1;
    @(posedge clk); #1;
    anahtar = rnd128(); sifre = rnd128();
    if (!hold) g_gecerli = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (hold) sifre = rnd128();
    end while (!c_gecerli && n < 40);
    g_gecerli = 1'b0;
    chk({tag, "_lat"}, 128'(n), 128'(lat));
    chk({tag, "_blok"}, blok, pt);
    chk({tag, "_hazir"}, {127'd0, hazir}, 128'd1);
    exp_pulses++;
    cvalid = CACHE;
    ckey = k;
  endtask

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;

  initial begin
    logic [127:0] k, p, c, p2, c2;
    build_sbox();
    rst = 1'b0; g_gecerli = 1'b0; anahtar = '0; sifre = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hazir", {127'd0, hazir}, 128'd1);
    chk("rst_blok", blok, 128'd0);
    chk("rst_cg", {127'd0, c_gecerli}, 128'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    run_blk("c1", K1, C1, P1, 1'b0);
    @(posedge clk); #1;
    chk("c1_pulse_end", {127'd0, c_gecerli}, 128'd0);

    run_blk("appb", KB, CB, PB, 1'b0);
    run_blk("appb_b2b", KB, CB, PB, 1'b0);   // submitted in the c_gecerli cycle
    @(posedge clk); #1;

    run_blk("busy", K1, C1, P1, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // reset pulse at edge T+5 of a C.1 decryption
    anahtar = K1; sifre = C1; g_gecerli = 1'b1;
    @(posedge clk); #1; g_gecerli = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #2;
    chk("abort_hazir", {127'd0, hazir}, 128'd1);
    chk("abort_blok", blok, 128'd0);
    chk("abort_cg", {127'd0, c_gecerli}, 128'd0);
    @(negedge clk); rst = 1'b1;
    cvalid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("abort_no_pulse", 128'(npulse), 128'(exp_pulses));
    run_blk("c1_after_rst", K1, C1, P1, 1'b0);
    @(posedge clk); #1;

    // key 0 and plaintext bytes 00/52 force S-box inputs 00 and 52 in round
    // one, so the inverse sees state bytes 63 and 00 on the way back
    k = '0;
    p = 128'h00520052_52005200_00000000_52525252;
    encrypt(k, p, c);
    run_blk("sbox_corner", k, c, p, 1'b0);
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) begin
      k = rnd128(); p = rnd128(); p2 = rnd128();
      encrypt(k, p, c);
      encrypt(k, p2, c2);
      run_blk($sformatf("rnd%0d_a", i), k, c, p, 1'b0);
      run_blk($sformatf("rnd%0d_b", i), k, c2, p2, 1'b0);
      @(posedge clk); #1;
    end

    repeat (5) @(posedge clk);
    #1;
    chk("pulse_count", 128'(npulse), 128'(exp_pulses));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aes_decrypt_engine.md
Name: aes_decrypt_engine

Overview:
Iterative AES-128 decryption engine (FIPS-197 inverse cipher). It is the receive-side counterpart of the pipelined encryption engine and uses the same Turkish-named key/block/valid/ready interface. It expands the key internally, then runs one inverse round per clock. The plaintext is presented with a one-cycle valid pulse.

Parameters:
NR, 10, number of AES rounds. Fixed for AES-128; any other value is unsupported.

Ports:
clk  input  1  single clock, all logic on posedge
rst  input  1  asynchronous, active-low reset
anahtar  input  128  cipher key, byte 0 in bits [127:120]
sifre  input  128  ciphertext block, byte 0 in bits [127:120]
g_gecerli  input  1  input valid; transfer occurs when g_gecerli && hazir at posedge
hazir  output  1  engine idle and able to accept
blok  output  128  recovered plaintext, registered
c_gecerli  output  1  one-cycle pulse; blok is valid while high

Behaviour:
- Reset (rst=0, async):
  - FSM goes to IDLE.
  - blok=0, c_gecerli=0, hazir=1 after release.
  - Round-key store cleared; key_valid=0.
- FSM states: IDLE, EXPAND, INIT, ROUND.
- IDLE:
  - hazir=1 (combinational from state==IDLE).
  - On accept at edge T, capture anahtar and sifre into internal registers.
  - If key cache hit (see Optional Feature): load state=sifre^rk[10] at T, set rcnt=9, go to ROUND.
  - Otherwise: rk[0]=anahtar, kcnt=1, go to EXPAND.
- EXPAND:
  - Each edge computes rk[kcnt] from rk[kcnt-1] using RotWord, SubWord and Rcon[kcnt] (01,02,04,08,10,20,40,80,1b,36).
  - Runs 10 edges (T+1..T+10), then sets key_valid=1 and goes to INIT.
- INIT: at edge T+11, state=sifre_reg^rk[10], rcnt=9, go to ROUND.
- ROUND:
  - For rcnt 9..1: state = InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[rcnt]), then decrement rcnt.
  - For rcnt=0: blok = InvSubBytes(InvShiftRows(state)) ^ rk[0]; pulse c_gecerli=1; go to IDLE.
- Latency (accept edge T to edge that registers blok):
  - Cache hit: T+10, i.e. c_gecerli high in the cycle after edge T+10.
  - Miss: T+21.
- Throughput:
  - hazir is high again in the same cycle as c_gecerli, so back-to-back accept is legal.
  - One block per 11 cycles on cache hit.
- g_gecerli while hazir=0 is ignored. No queuing; inputs need not be held after accept.
- blok holds its value until the next completion. c_gecerli is high for exactly one cycle per accepted block.
- S-box and inverse S-box:
  - Computed arithmetically: GF(2^8) inverse via x^254 with polynomial 0x11b, plus the affine transform (inverse affine first for InvSubBytes).
  - 0 maps to 0x63 forward, and 0x63 maps to 0 inverse.
  - No 256-entry tables.
- InvMixColumns coefficients: 0e, 0b, 0d, 09, with xtime-based multiplies.
- Reset asserted mid-EXPAND or mid-ROUND aborts the operation: no c_gecerli, key_valid=0, next block does a full expansion.

Optional Feature:
- Macro: AES_DEC_KEYCACHE_EN.
- Defined:
  - rk[0..10] and the captured key are retained after completion.
  - On accept, if key_valid && anahtar==cached key, EXPAND/INIT are skipped (hit path, latency 10).
  - A differing key clears key_valid and re-expands.
- Undefined:
  - Every accept takes the miss path (latency 21).
  - key_valid logic and the 128-bit comparator are omitted.

Test Plan:
- FIPS-197 C.1: anahtar=000102030405060708090a0b0c0d0e0f, sifre=69c4e0d86a7b0430d8cdb78070b4c55a -> blok=00112233445566778899aabbccddeeff, c_gecerli exactly 1 cycle, 21 edges after accept.
- FIPS-197 App. B: anahtar=2b7e151628aed2a6abf7158809cf4f3c, sifre=3925841d02dc09fbdc118597196a0b32 -> blok=3243f6a8885a308d313198a2e0370734.
- Same key as App. B resubmitted back-to-back in the c_gecerli cycle -> accepted immediately; result after 10 edges with AES_DEC_KEYCACHE_EN, 21 edges without.
- g_gecerli held high with changing sifre during a busy period -> only the block present at the accept edge is decrypted; no extra c_gecerli pulses.
- rst pulsed low at edge T+5 of a C.1 decryption -> blok=0, c_gecerli never asserts, hazir=1. A resubmitted C.1 vector then yields the correct plaintext after 21 edges.
- S-box corner check via a vector with ciphertext bytes forcing state bytes 00 and 63 -> matches the software reference model bit-exact.
